// File: rtl/rs_syndrome_calc.sv
// Streaming RS syndrome stage: Horner-evaluates each incoming codeword at
// alpha^1..alpha^ROOTS_NUM and hands the syndrome vector off via valid/ready.
`ifndef N_LEN
`define N_LEN 255
`endif
`ifndef K_LEN
`define K_LEN 239
`endif
`ifndef SYMB_WIDTH
`define SYMB_WIDTH 8
`endif
`ifndef BUS_WIDTH_IN_SYMB
`define BUS_WIDTH_IN_SYMB 4
`endif

package gf_pkg;
  localparam int GF_WIDTH = 8;
  localparam logic [GF_WIDTH:0] GF_POLY = 9'h11D;
  typedef logic [GF_WIDTH-1:0] gf_t;

  function automatic gf_t gf_mult(input gf_t a, input gf_t b);
    gf_t p;
    gf_t aa;
    logic carry;
    p  = {GF_WIDTH{1'b0}};
    aa = a;
    for (int i = 0; i < GF_WIDTH; i++) begin
      if (b[i]) p = p ^ aa;
      carry = aa[GF_WIDTH-1];
      aa    = {aa[GF_WIDTH-2:0], 1'b0};
      if (carry) aa = aa ^ GF_POLY[GF_WIDTH-1:0];
    end
    return p;
  endfunction

  function automatic gf_t gf_alpha_pow(input int n);
    gf_t r;
    r = {{(GF_WIDTH-1){1'b0}}, 1'b1};
    for (int i = 0; i < n; i++) r = gf_mult(r, {{(GF_WIDTH-2){1'b0}}, 2'b10});
    return r;
  endfunction
endpackage

module rs_syndrome_calc #(
  parameter int N_LEN             = `N_LEN,
  parameter int K_LEN             = `K_LEN,
  parameter int SYMB_WIDTH        = `SYMB_WIDTH,
  parameter int BUS_WIDTH_IN_SYMB = `BUS_WIDTH_IN_SYMB,
  localparam int ROOTS_NUM        = N_LEN - K_LEN,
  localparam int W                = BUS_WIDTH_IN_SYMB,
  localparam int CW               = $clog2(N_LEN + W + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [W*SYMB_WIDTH-1:0]         s_tdata,
  input  logic [W-1:0]                    s_tkeep,
  input  logic                            s_tvalid,
  input  logic                            s_tlast,
  output logic                            s_tready,
  output logic [ROOTS_NUM*SYMB_WIDTH-1:0] m_synd,
  output logic                            m_err_det,
  output logic                            m_len_err,
  output logic                            m_valid,
  input  logic                            m_ready
);
  import gf_pkg::*;

  localparam logic [CW-1:0] N_LEN_C = CW'(N_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2} state_e;

  state_e                          state_q, state_d;
  logic [ROOTS_NUM*SYMB_WIDTH-1:0] acc_q, acc_d, m_synd_q, m_synd_d;
  logic [ROOTS_NUM*SYMB_WIDTH-1:0] base_s, horner_s;
  logic [CW-1:0]                   cnt_q, cnt_d, cnt_base_s, cnt_add_s;
  logic [CW:0]                     keep_cnt_s, cnt_sum_s;
  logic                            s_tready_q, s_tready_d, m_valid_q, m_valid_d;
  logic                            m_err_det_q, m_err_det_d, m_len_err_q, m_len_err_d;
  logic                            beat_s;

  // A new codeword always starts from a zero accumulator, whatever acc_q holds.
  assign base_s     = (state_q == IDLE) ? {(ROOTS_NUM*SYMB_WIDTH){1'b0}} : acc_q;
  assign cnt_base_s = (state_q == IDLE) ? {CW{1'b0}} : cnt_q;
  assign beat_s     = s_tvalid && s_tready_q;

  for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_root
    localparam gf_t ROOT = gf_alpha_pow(j + 1);
    gf_t h_s;
    always_comb begin
      h_s = base_s[j*SYMB_WIDTH +: SYMB_WIDTH];
      for (int l = 0; l < W; l++) begin
        if (s_tkeep[l]) begin
          h_s = gf_mult(h_s, ROOT) ^ s_tdata[l*SYMB_WIDTH +: SYMB_WIDTH];
        end else begin
          h_s = h_s;
        end
      end
    end
    assign horner_s[j*SYMB_WIDTH +: SYMB_WIDTH] = h_s;
  end

  // Saturating symbol count, so an over-long codeword still reads as a length error.
  always_comb begin
    keep_cnt_s = {(CW+1){1'b0}};
    for (int l = 0; l < W; l++) keep_cnt_s = keep_cnt_s + {{CW{1'b0}}, s_tkeep[l]};
    cnt_sum_s = {1'b0, cnt_base_s} + keep_cnt_s;
    cnt_add_s = cnt_sum_s[CW] ? {CW{1'b1}} : cnt_sum_s[CW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    m_synd_d    = m_synd_q;
    m_err_det_d = m_err_det_q;
    m_len_err_d = m_len_err_q;
    m_valid_d   = m_valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat_s) begin
          acc_d = horner_s;
          cnt_d = cnt_add_s;
          if (s_tlast) begin
            state_d     = OUT;
            m_synd_d    = horner_s;
            m_err_det_d = |horner_s;
            m_len_err_d = (cnt_add_s != N_LEN_C);
            m_valid_d   = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d   = IDLE;
          acc_d     = {(ROOTS_NUM*SYMB_WIDTH){1'b0}};
          cnt_d     = {CW{1'b0}};
          m_valid_d = 1'b0;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d   = IDLE;
        acc_d     = {(ROOTS_NUM*SYMB_WIDTH){1'b0}};
        cnt_d     = {CW{1'b0}};
        m_valid_d = 1'b0;
      end
    endcase
    s_tready_d = (state_d != OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {(ROOTS_NUM*SYMB_WIDTH){1'b0}};
      cnt_q       <= {CW{1'b0}};
      m_synd_q    <= {(ROOTS_NUM*SYMB_WIDTH){1'b0}};
      m_err_det_q <= 1'b0;
      m_len_err_q <= 1'b0;
      m_valid_q   <= 1'b0;
      s_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      m_synd_q    <= m_synd_d;
      m_err_det_q <= m_err_det_d;
      m_len_err_q <= m_len_err_d;
      m_valid_q   <= m_valid_d;
      s_tready_q  <= s_tready_d;
    end
  end

  assign s_tready  = s_tready_q;
  assign m_synd    = m_synd_q;
  assign m_err_det = m_err_det_q;
  assign m_len_err = m_len_err_q;
  assign m_valid   = m_valid_q;
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: table-based GF(256) reference, software RS encoder,
// and a scoreboard of expected syndrome results.
module tb_rs_syndrome_calc;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_tdata = 32'h0;
  logic [3:0]   s_tkeep = 4'h0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [127:0] m_synd;
  logic         m_err_det, m_len_err, m_valid;
  logic         m_ready = 1'b0;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [127:0] synd;
    logic         err;
    logic         len;
  } exp_t;
  exp_t sb[$];

  logic [7:0] cw[$];
  int gf_exp[0:254];
  int gf_log[0:255];

  rs_syndrome_calc dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_synd(m_synd), .m_err_det(m_err_det),
    .m_len_err(m_len_err), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gf_exp[(gf_log[a] + gf_log[b]) % 255];
  endfunction

  // Direct evaluation S_j = sum c_i * alpha^((j+1)*i), last symbol is c_0.
  function automatic logic [127:0] synd_model();
    logic [127:0] r;
    int m;
    int s;
    r = 128'h0;
    m = cw.size();
    for (int j = 0; j < 16; j++) begin
      s = 0;
      for (int k = 0; k < m; k++) begin
        if (cw[k] != 8'h00) s = s ^ gf_exp[(gf_log[cw[k]] + (j + 1) * (m - 1 - k)) % 255];
      end
      r[j*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic fill(input int n, input bit rnd);
    cw.delete();
    for (int k = 0; k < n; k++) cw.push_back(rnd ? 8'($urandom()) : 8'h00);
  endtask

  // Systematic RS(255,239) encoder, generator roots alpha^1..alpha^16.
  task automatic encode_random();
    int g[0:16];
    int p[0:15];
    int fb;
    int msg;
    for (int k = 0; k <= 16; k++) g[k] = 0;
    g[0] = 1;
    for (int j = 1; j <= 16; j++) begin
      for (int k = 16; k >= 1; k--) g[k] = g[k-1] ^ gmul(g[k], gf_exp[j]);
      g[0] = gmul(g[0], gf_exp[j]);
    end
    for (int k = 0; k < 16; k++) p[k] = 0;
    cw.delete();
    for (int k = 0; k < 239; k++) begin
      msg = $urandom_range(255, 0);
      cw.push_back(8'(msg));
      fb = msg ^ p[15];
      for (int t = 15; t >= 1; t--) p[t] = p[t-1] ^ gmul(fb, g[t]);
      p[0] = gmul(fb, g[0]);
    end
    for (int t = 15; t >= 0; t--) cw.push_back(8'(p[t]));
  endtask

  task automatic send_cw(input bit empty_last);
    int m;
    int nb;
    int k;
    int guard;
    exp_t e;
    logic [31:0] d;
    logic [3:0] kp;
    m = cw.size();
    k = 0;
    nb = empty_last ? (m / 4 + 1) : ((m + 3) / 4);
    for (int b = 0; b < nb; b++) begin
      d = $urandom();
      kp = 4'h0;
      for (int l = 0; l < 4; l++) begin
        if (k < m && !(empty_last && b == nb - 1)) begin
          d[l*8 +: 8] = cw[k];
          kp[l] = 1'b1;
          k++;
        end
      end
      s_tdata = d; s_tkeep = kp; s_tlast = (b == nb - 1); s_tvalid = 1'b1;
      guard = 0;
      while (!s_tready && guard < 100) begin @(posedge clk); #1; guard++; end
      if (!s_tready) begin
        total++;
        $display("FAIL send_ready_timeout: s_tready=%0b required 1", s_tready);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 4'h0;
    e.synd = synd_model();
    e.err  = |e.synd;
    e.len  = (m != 255);
    sb.push_back(e);
  endtask

  task automatic collect(input string name);
    exp_t e;
    int guard;
    guard = 0;
    while (!m_valid && guard < 200) begin @(posedge clk); #1; guard++; end
    total++;
    if (m_valid !== 1'b1) $display("FAIL %s_valid_timeout: m_valid=%0b required 1", name, m_valid);
    else passed++;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s_scoreboard_empty: entries=0 required 1", name);
    end else begin
      e = sb.pop_front();
      total++;
      if (m_synd !== e.synd) $display("FAIL %s_synd: got %h required %h", name, m_synd, e.synd);
      else passed++;
      total++;
      if (m_err_det !== e.err) $display("FAIL %s_err_det: got %0b required %0b", name, m_err_det, e.err);
      else passed++;
      total++;
      if (m_len_err !== e.len) $display("FAIL %s_len_err: got %0b required %0b", name, m_len_err, e.len);
      else passed++;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0 || s_tready !== 1'b1)
      $display("FAIL %s_release: m_valid=%0b s_tready=%0b required 0/1", name, m_valid, s_tready);
    else passed++;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (s_tready !== 1'b0 || m_valid !== 1'b0 || m_synd !== 128'h0 || m_err_det !== 1'b0 || m_len_err !== 1'b0)
      $display("FAIL %s_in_reset: tready=%0b valid=%0b synd=%h err=%0b len=%0b required 0/0/0/0/0",
               name, s_tready, m_valid, m_synd, m_err_det, m_len_err);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (s_tready !== 1'b1 || m_valid !== 1'b0)
      $display("FAIL %s_after_reset: tready=%0b valid=%0b required 1/0", name, s_tready, m_valid);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_zero();
    fill(255, 1'b0);
    send_cw(1'b0);
    total++;
    if (m_valid !== 1'b1) $display("FAIL zero_latency: m_valid=%0b required 1", m_valid);
    else passed++;
    total++;
    if (m_synd !== 128'h0 || m_err_det !== 1'b0 || m_len_err !== 1'b0)
      $display("FAIL zero_const: synd=%h err=%0b len=%0b required 0/0/0", m_synd, m_err_det, m_len_err);
    else passed++;
    collect("zero");
  endtask

  task automatic test_single_symbols();
    fill(255, 1'b0);
    cw[254] = 8'h01;
    send_cw(1'b0);
    total++;
    if (m_synd !== {16{8'h01}} || m_err_det !== 1'b1)
      $display("FAIL c0_const: synd=%h err=%0b required all 01 / 1", m_synd, m_err_det);
    else passed++;
    collect("c0");
    fill(255, 1'b0);
    cw[0] = 8'h01;
    send_cw(1'b0);
    total++;
    if (m_synd[7:0] !== 8'h8E || m_synd[15:8] !== 8'h47 || m_err_det !== 1'b1)
      $display("FAIL c254_const: s0=%h s1=%h err=%0b required 8e/47/1", m_synd[7:0], m_synd[15:8], m_err_det);
    else passed++;
    collect("c254");
  endtask

  task automatic test_rs_codeword();
    int pos;
    encode_random();
    send_cw(1'b0);
    total++;
    if (m_synd !== 128'h0 || m_err_det !== 1'b0)
      $display("FAIL clean_cw: synd=%h err=%0b required 0/0", m_synd, m_err_det);
    else passed++;
    collect("clean_cw");
    pos = $urandom_range(254, 0);
    cw[pos] = cw[pos] ^ 8'($urandom_range(255, 1));
    send_cw(1'b0);
    total++;
    if (m_err_det !== 1'b1) $display("FAIL err_cw_det: got %0b required 1", m_err_det);
    else passed++;
    collect("err_cw");
  endtask

  task automatic test_back_to_back();
    logic [127:0] held;
    fill(255, 1'b1);
    send_cw(1'b0);
    held = sb[0].synd;
    fill(255, 1'b1);
    fork
      send_cw(1'b0);
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          total++;
          if (s_tready !== 1'b0 || m_synd !== held)
            $display("FAIL stall_hold: tready=%0b synd=%h required 0/%h", s_tready, m_synd, held);
          else passed++;
        end
        collect("stall_first");
      end
    join
    collect("stall_second");
  endtask

  task automatic test_len_err();
    fill(200, 1'b1);
    send_cw(1'b0);
    collect("short_200");
    fill(260, 1'b1);
    send_cw(1'b0);
    collect("long_260");
    fill(252, 1'b1);
    send_cw(1'b1);
    collect("empty_last");
  endtask

  task automatic test_reset_mid();
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tkeep = 4'hF;
    for (int b = 0; b < 30; b++) begin
      s_tdata = $urandom();
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tkeep = 4'h0;
    do_reset("mid_reset");
    fill(255, 1'b0);
    send_cw(1'b0);
    total++;
    if (m_synd !== 128'h0 || m_err_det !== 1'b0 || m_len_err !== 1'b0)
      $display("FAIL post_reset_zero: synd=%h err=%0b len=%0b required 0/0/0", m_synd, m_err_det, m_len_err);
    else passed++;
    collect("post_reset");
  endtask

  initial begin
    gf_exp[0] = 1;
    for (int i = 1; i < 255; i++) begin
      gf_exp[i] = gf_exp[i-1] << 1;
      if (gf_exp[i] > 255) gf_exp[i] = gf_exp[i] ^ 285;
    end
    gf_log[0] = 0;
    for (int i = 0; i < 255; i++) gf_log[gf_exp[i]] = i;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_zero();
    test_single_symbols();
    test_rs_codeword();
    test_back_to_back();
    test_len_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
Streaming syndrome stage of the RS(N_LEN,K_LEN) decoder. It sits directly upstream of the Berlekamp-Massey block. It accepts a received codeword as a symbol stream, BUS_WIDTH_IN_SYMB symbols per beat. It evaluates the codeword polynomial at ROOTS_NUM consecutive roots using gf_pkg arithmetic. It then presents the syndrome vector and an error-detected flag through a valid/ready handshake.

Parameters:
N_LEN, `N_LEN (255), codeword length in symbols.
K_LEN, `K_LEN (239), message length; ROOTS_NUM = N_LEN-K_LEN syndromes.
SYMB_WIDTH, `SYMB_WIDTH (8), bits per symbol; field polynomial is POLY (285).
BUS_WIDTH_IN_SYMB, `BUS_WIDTH_IN_SYMB (4), symbols per input beat (W).

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous active-high reset.
s_tdata  in  W*SYMB_WIDTH  input symbols; lane 0 (LSBs) is earliest in time.
s_tkeep  in  W  lane valid mask; contiguous from lane 0; all-ones except possibly on the tlast beat.
s_tvalid  in  1  input beat valid.
s_tlast  in  1  last beat of codeword.
s_tready  out  1  input ready.
m_synd  out  ROOTS_NUM*SYMB_WIDTH  syndromes; S_j in bits [j*SYMB_WIDTH +: SYMB_WIDTH].
m_err_det  out  1  OR of all syndromes being non-zero.
m_len_err  out  1  accepted symbol count at tlast != N_LEN.
m_valid  out  1  syndrome output valid.
m_ready  in  1  downstream ready.

Behaviour:
- Symbol order: the first symbol received is c_{N_LEN-1}; the last is c_0. S_j = sum c_i * alpha^((j+1)*i), j = 0..ROOTS_NUM-1. Root j is alpha^(FIRST_ROOT+j).
- Per-beat update, for each j, Horner across valid lanes in lane order: acc = acc*r_j ^ d_lane. Invalid lanes are skipped and do not multiply. Use gf_mult from gf_pkg. Combinational chain depth is W multiplies; no extra pipeline.
- Beat accepted when s_tvalid && s_tready.
- Symbol counter: width $clog2(N_LEN+W+1). Adds popcount(s_tkeep) per accepted beat. Saturates at its maximum rather than wrapping.
- FSM states:
  - IDLE: acc = 0, cnt = 0, s_tready = 1. On the first accepted beat, load acc with that beat's Horner result starting from 0. Go to ACCUM, or to OUT if s_tlast is set.
  - ACCUM: s_tready = 1; accumulate each beat. On an accepted beat with s_tlast, go to OUT.
  - OUT: s_tready = 0, m_valid = 1. m_synd, m_err_det and m_len_err are registered and held stable. On m_ready, return to IDLE with acc and cnt cleared.
- Latency: m_valid asserts the cycle after the tlast beat is accepted.
- No input is accepted while in OUT; the upstream stalls. Back-to-back codewords therefore lose one bubble cycle per codeword, plus any downstream stall time.
- m_len_err = (cnt_final != N_LEN). Syndromes are still output for short or long codewords.
- tlast on a beat with s_tkeep = 0: the beat contributes nothing, but the codeword still terminates.
- Reset, including mid-codeword:
  - State goes to IDLE; acc, cnt, m_synd all zero.
  - m_valid = 0, m_err_det = 0, m_len_err = 0.
  - s_tready = 0 during the reset cycle and 1 from the following cycle.
  - A partial codeword in progress is discarded.
- m_synd changes only on the OUT entry edge.

Test Plan:
- All-zero codeword, 64 beats, last s_tkeep = 4'b0111 -> m_synd all 0x00, m_err_det = 0, m_len_err = 0, m_valid one cycle after the tlast beat.
- Zero codeword except last symbol c_0 = 0x01 -> every S_j = 0x01, m_err_det = 1.
- Zero codeword except first symbol c_254 = 0x01 -> S_0 = alpha^254 = 0x8E, S_1 = alpha^253 = 0x47, m_err_det = 1.
- Valid RS(255,239) codeword from the software encoder, one random symbol error injected -> syndromes match the reference model, m_err_det = 1. The clean codeword gives all zeros.
- Hold m_ready = 0 for 20 cycles while a second codeword is presented -> s_tready stays 0, m_synd stays stable. After m_ready, the second codeword is processed correctly.
- tlast after 200 symbols -> m_len_err = 1. Reset asserted mid-codeword, then a full zero codeword -> output all zero, with no contamination from the aborted codeword.
